// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank: NUM_REGS words, optional read-only slots
// fed from ro_d_i, and a one-cycle write pulse per committed write.
module axi_lite_regfile #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS = 8,
   parameter logic [NUM_REGS-1:0] RO_MASK = '0,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic [ADDR_WIDTH-1:0]          aw_addr_i,
   input  logic                           aw_valid_i,
   output logic                           aw_ready_o,
   input  logic [DATA_WIDTH-1:0]          w_data_i,
   input  logic [STRB_WIDTH-1:0]          w_strb_i,
   input  logic                           w_valid_i,
   output logic                           w_ready_o,
   output logic [1:0]                     b_resp_o,
   output logic                           b_valid_o,
   input  logic                           b_ready_i,
   input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
   input  logic                           ar_valid_i,
   output logic                           ar_ready_o,
   output logic [DATA_WIDTH-1:0]          r_data_o,
   output logic [1:0]                     r_resp_o,
   output logic                           r_valid_o,
   input  logic                           r_ready_i,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q_o,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d_i,
   output logic [NUM_REGS-1:0]            wr_pulse_o
);

   localparam int OFS = $clog2(STRB_WIDTH);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] bank_t;

   bank_t regs_q, regs_d;
   bank_t ro_d;
   bank_t reg_view;

   logic                  aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
   logic                  b_valid_q, b_valid_d;
   logic [1:0]            b_resp_q, b_resp_d;
   logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
   logic                  r_valid_q, r_valid_d;
   logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
   logic [1:0]            r_resp_q, r_resp_d;

   logic             aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0] w_idx, r_idx;
   logic             w_ok, r_in;
   logic [DATA_WIDTH-1:0] rd_val;

   // Any address bit above the word index puts the access out of range.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
      return (a >> (OFS + IDX_W)) == '0;
   endfunction

   assign ro_d = ro_d_i;

   assign aw_ready_o = !aw_held_q && !b_valid_q;
   assign w_ready_o  = !w_held_q && !b_valid_q;
   assign ar_ready_o = !r_valid_q;

   assign aw_hs = aw_valid_i && aw_ready_o;
   assign w_hs  = w_valid_i && w_ready_o;
   assign ar_hs = ar_valid_i && ar_ready_o;

   assign w_idx = aw_addr_q[OFS +: IDX_W];
   assign w_ok  = in_range(aw_addr_q) && !RO_MASK[w_idx];
   assign r_idx = ar_addr_i[OFS +: IDX_W];
   assign r_in  = in_range(ar_addr_i);
   assign rd_val = RO_MASK[r_idx] ? ro_d[r_idx] : regs_q[r_idx];

   always_comb begin
      aw_held_d  = aw_held_q;
      aw_addr_d  = aw_addr_q;
      w_held_d   = w_held_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      b_valid_d  = b_valid_q;
      b_resp_d   = b_resp_q;
      regs_d     = regs_q;
      wr_pulse_d = '0;
      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = aw_addr_i;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = w_data_i;
         w_strb_d = w_strb_i;
      end
      if (b_valid_q && b_ready_i) begin
         b_valid_d = 1'b0;
      end
      if (aw_held_q && w_held_q) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         b_valid_d = 1'b1;
         if (w_ok) begin
            for (int k = 0; k < STRB_WIDTH; k++) begin
               if (w_strb_q[k]) begin
                  regs_d[w_idx][8*k +: 8] = w_data_q[8*k +: 8];
               end
            end
            wr_pulse_d[w_idx] = 1'b1;
            b_resp_d = OKAY;
         end else begin
            b_resp_d = SLVERR;
         end
      end
   end

   // Reads sample regs_q, so a read racing a commit sees the old value.
   always_comb begin
      r_valid_d = r_valid_q;
      r_data_d  = r_data_q;
      r_resp_d  = r_resp_q;
      if (r_valid_q && r_ready_i) begin
         r_valid_d = 1'b0;
      end
      if (ar_hs) begin
         r_valid_d = 1'b1;
         if (r_in) begin
            r_data_d = rd_val;
            r_resp_d = OKAY;
         end else begin
            r_data_d = '0;
            r_resp_d = SLVERR;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regs_q     <= '0;
         aw_held_q  <= 1'b0;
         aw_addr_q  <= '0;
         w_held_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= '0;
         wr_pulse_q <= '0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
      end else begin
         regs_q     <= regs_d;
         aw_held_q  <= aw_held_d;
         aw_addr_q  <= aw_addr_d;
         w_held_q   <= w_held_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         b_valid_q  <= b_valid_d;
         b_resp_q   <= b_resp_d;
         wr_pulse_q <= wr_pulse_d;
         r_valid_q  <= r_valid_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
      end
   end

   always_comb begin
      reg_view = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (!RO_MASK[i]) begin
            reg_view[i] = regs_q[i];
         end
      end
   end

   assign reg_q_o    = reg_view;
   assign wr_pulse_o = wr_pulse_q;
   assign b_valid_o  = b_valid_q;
   assign b_resp_o   = b_resp_q;
   assign r_valid_o  = r_valid_q;
   assign r_data_o   = r_data_q;
   assign r_resp_o   = r_resp_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Scenario bench for axi_lite_regfile: B/R beats are checked against
// queued expectations; timing and side effects are checked inline.
module tb_axi_lite_regfile;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NR = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_i;
   logic [AW-1:0] aw_addr_i, ar_addr_i;
   logic aw_valid_i, aw_ready_o, w_valid_i, w_ready_o;
   logic [DW-1:0] w_data_i, r_data_o;
   logic [3:0] w_strb_i;
   logic [1:0] b_resp_o, r_resp_o;
   logic b_valid_o, b_ready_i, ar_valid_i, ar_ready_o;
   logic r_valid_o, r_ready_i;
   logic [NR*DW-1:0] reg_q_o, ro_d_i;
   logic [NR-1:0] wr_pulse_o;

   int total = 0;
   int bad = 0;
   logic [1:0] exp_b[$];
   logic [33:0] exp_r[$];
   logic [1:0] eb;
   logic [33:0] er;

   axi_lite_regfile #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .RO_MASK(8'h01)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i),
      .w_ready_o(w_ready_o),
      .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o),
      .r_ready_i(r_ready_i),
      .reg_q_o(reg_q_o), .ro_d_i(ro_d_i), .wr_pulse_o(wr_pulse_o)
   );

   // B and R scoreboards: handshake will happen at the next rising edge.
   always @(negedge clk) begin
      if (!rst_i && b_valid_o && b_ready_i) begin
         total++;
         if (exp_b.size() == 0) begin
            bad++;
            $display("FAIL b_unexpected got resp=%0h", b_resp_o);
         end else begin
            eb = exp_b.pop_front();
            if (b_resp_o !== eb) begin
               bad++;
               $display("FAIL b_resp got=%0h exp=%0h", b_resp_o, eb);
            end
         end
      end
      if (!rst_i && r_valid_o && r_ready_i) begin
         total++;
         if (exp_r.size() == 0) begin
            bad++;
            $display("FAIL r_unexpected got data=%h resp=%0h", r_data_o, r_resp_o);
         end else begin
            er = exp_r.pop_front();
            if ({r_resp_o, r_data_o} !== er) begin
               bad++;
               $display("FAIL r_beat got resp=%0h data=%h exp resp=%0h data=%h",
                        r_resp_o, r_data_o, er[33:32], er[31:0]);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw(input logic [31:0] a);
      aw_addr_i = a;
      aw_valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (aw_ready_o) begin
            tick();
            aw_valid_i = 1'b0;
            return;
         end
         tick();
      end
      total++; bad++;
      $display("FAIL aw_timeout got ready=0 exp ready=1");
      aw_valid_i = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      w_data_i = d;
      w_strb_i = s;
      w_valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (w_ready_o) begin
            tick();
            w_valid_i = 1'b0;
            return;
         end
         tick();
      end
      total++; bad++;
      $display("FAIL w_timeout got ready=0 exp ready=1");
      w_valid_i = 1'b0;
   endtask

   task automatic send_both(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
      logic ah, wh;
      aw_addr_i = a; w_data_i = d; w_strb_i = s;
      aw_valid_i = 1'b1; w_valid_i = 1'b1;
      for (int c = 0; c < 20 && (aw_valid_i || w_valid_i); c++) begin
         ah = aw_valid_i && aw_ready_o;
         wh = w_valid_i && w_ready_o;
         tick();
         if (ah) aw_valid_i = 1'b0;
         if (wh) w_valid_i = 1'b0;
      end
      if (aw_valid_i || w_valid_i) begin
         total++; bad++;
         $display("FAIL aww_timeout got pending=1 exp pending=0");
         aw_valid_i = 1'b0; w_valid_i = 1'b0;
      end
   endtask

   task automatic send_ar(input logic [31:0] a);
      ar_addr_i = a;
      ar_valid_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (ar_ready_o) begin
            tick();
            ar_valid_i = 1'b0;
            return;
         end
         tick();
      end
      total++; bad++;
      $display("FAIL ar_timeout got ready=0 exp ready=1");
      ar_valid_i = 1'b0;
   endtask

   task automatic wait_b();
      for (int c = 0; c < 20; c++) begin
         if (b_valid_o) begin
            b_ready_i = 1'b1;
            tick();
            b_ready_i = 1'b0;
            return;
         end
         tick();
      end
      total++; bad++;
      $display("FAIL b_timeout got valid=0 exp valid=1");
   endtask

   task automatic wait_r();
      for (int c = 0; c < 20; c++) begin
         if (r_valid_o) begin
            r_ready_i = 1'b1;
            tick();
            r_ready_i = 1'b0;
            return;
         end
         tick();
      end
      total++; bad++;
      $display("FAIL r_timeout got valid=0 exp valid=1");
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      tick();
      total++; if ({b_valid_o, r_valid_o} !== 2'b00) begin bad++; $display("FAIL rst_valids got=%b exp=00", {b_valid_o, r_valid_o}); end
      total++; if ({aw_ready_o, w_ready_o, ar_ready_o} !== 3'b111) begin bad++; $display("FAIL rst_readies got=%b exp=111", {aw_ready_o, w_ready_o, ar_ready_o}); end
      total++; if (reg_q_o !== '0) begin bad++; $display("FAIL rst_regs got=%h exp=0", reg_q_o); end
      total++; if ({wr_pulse_o, b_resp_o, r_resp_o, r_data_o} !== '0) begin bad++; $display("FAIL rst_misc got pulse=%h b=%0h r=%0h d=%h exp 0", wr_pulse_o, b_resp_o, r_resp_o, r_data_o); end
   endtask

   task automatic test_basic();
      exp_b.push_back(2'b00);
      send_both(32'h4, 32'hDEADBEEF, 4'hF);
      total++; if (b_valid_o !== 1'b0) begin bad++; $display("FAIL basic_b_early got=%b exp=0", b_valid_o); end
      tick();
      total++; if (b_valid_o !== 1'b1) begin bad++; $display("FAIL basic_b_lat got=%b exp=1", b_valid_o); end
      total++; if (wr_pulse_o !== 8'h02) begin bad++; $display("FAIL basic_pulse got=%h exp=02", wr_pulse_o); end
      total++; if (reg_q_o[1*DW +: DW] !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_reg got=%h exp=deadbeef", reg_q_o[1*DW +: DW]); end
      total++; if ({aw_ready_o, w_ready_o} !== 2'b00) begin bad++; $display("FAIL basic_rdy_bpend got=%b exp=00", {aw_ready_o, w_ready_o}); end
      wait_b();
      total++; if (wr_pulse_o !== 8'h00) begin bad++; $display("FAIL basic_pulse_end got=%h exp=00", wr_pulse_o); end
      total++; if ({aw_ready_o, w_ready_o} !== 2'b11) begin bad++; $display("FAIL basic_rdy_back got=%b exp=11", {aw_ready_o, w_ready_o}); end
      exp_r.push_back({2'b00, 32'hDEADBEEF});
      send_ar(32'h4);
      total++; if (r_valid_o !== 1'b1) begin bad++; $display("FAIL basic_r_lat got=%b exp=1", r_valid_o); end
      wait_r();
   endtask

   task automatic test_order();
      send_w(32'h11223344, 4'h5);
      total++; if (w_ready_o !== 1'b0) begin bad++; $display("FAIL order_w_held got=%b exp=0", w_ready_o); end
      tick(); tick();
      total++; if ({w_ready_o, b_valid_o} !== 2'b00) begin bad++; $display("FAIL order_wait got=%b exp=00", {w_ready_o, b_valid_o}); end
      exp_b.push_back(2'b00);
      send_aw(32'h4);
      wait_b();
      total++; if (reg_q_o[1*DW +: DW] !== 32'hDE22BE44) begin bad++; $display("FAIL order_strb got=%h exp=de22be44", reg_q_o[1*DW +: DW]); end
      send_aw(32'h9);
      total++; if (aw_ready_o !== 1'b0) begin bad++; $display("FAIL order_aw_held got=%b exp=0", aw_ready_o); end
      tick();
      exp_b.push_back(2'b00);
      send_w(32'h12345678, 4'hF);
      wait_b();
      total++; if (reg_q_o[2*DW +: DW] !== 32'h12345678) begin bad++; $display("FAIL order_unaligned got=%h exp=12345678", reg_q_o[2*DW +: DW]); end
   endtask

   task automatic test_range();
      exp_b.push_back(2'b10);
      send_both(32'h40, 32'h55555555, 4'hF);
      tick();
      total++; if ({b_valid_o, wr_pulse_o} !== 9'h100) begin bad++; $display("FAIL range_pulse got=%h exp=100", {b_valid_o, wr_pulse_o}); end
      wait_b();
      total++; if (reg_q_o[0 +: 3*DW] !== {32'h12345678, 32'hDE22BE44, 32'h0}) begin bad++; $display("FAIL range_regs got=%h", reg_q_o[0 +: 3*DW]); end
      total++; if (reg_q_o[3*DW +: 5*DW] !== '0) begin bad++; $display("FAIL range_upper got=%h exp=0", reg_q_o[3*DW +: 5*DW]); end
      exp_r.push_back({2'b10, 32'h0});
      send_ar(32'h40);
      wait_r();
   endtask

   task automatic test_ro();
      exp_b.push_back(2'b10);
      send_both(32'h0, 32'h99999999, 4'hF);
      tick();
      total++; if (wr_pulse_o !== 8'h00) begin bad++; $display("FAIL ro_pulse got=%h exp=00", wr_pulse_o); end
      wait_b();
      total++; if (reg_q_o[0 +: DW] !== 32'h0) begin bad++; $display("FAIL ro_slice got=%h exp=0", reg_q_o[0 +: DW]); end
      exp_r.push_back({2'b00, 32'hCAFE0001});
      send_ar(32'h0);
      wait_r();
      exp_r.push_back({2'b00, 32'hDE22BE44});
      send_ar(32'h4);
      wait_r();
   endtask

   task automatic test_backpressure();
      exp_b.push_back(2'b00);
      send_both(32'hC, 32'hA5A5A5A5, 4'hF);
      tick();
      aw_addr_i = 32'h10; aw_valid_i = 1'b1;
      w_data_i = 32'h77777777; w_strb_i = 4'hF; w_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++; if ({b_valid_o, b_resp_o, aw_ready_o, w_ready_o} !== 5'b10000) begin bad++; $display("FAIL bp_b got=%b exp=10000", {b_valid_o, b_resp_o, aw_ready_o, w_ready_o}); end
         tick();
      end
      aw_valid_i = 1'b0; w_valid_i = 1'b0;
      wait_b();
      tick(); tick();
      total++; if (b_valid_o !== 1'b0) begin bad++; $display("FAIL bp_extra_b got=%b exp=0", b_valid_o); end
      total++; if (reg_q_o[4*DW +: DW] !== 32'h0) begin bad++; $display("FAIL bp_blocked got=%h exp=0", reg_q_o[4*DW +: DW]); end
      exp_r.push_back({2'b00, 32'hA5A5A5A5});
      send_ar(32'hC);
      ar_addr_i = 32'h4; ar_valid_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         total++; if ({r_valid_o, r_resp_o, ar_ready_o, r_data_o} !== {1'b1, 2'b00, 1'b0, 32'hA5A5A5A5}) begin bad++; $display("FAIL bp_r got v=%b resp=%0h rdy=%b d=%h", r_valid_o, r_resp_o, ar_ready_o, r_data_o); end
         tick();
      end
      ar_valid_i = 1'b0;
      wait_r();
      tick();
      total++; if (r_valid_o !== 1'b0) begin bad++; $display("FAIL bp_extra_r got=%b exp=0", r_valid_o); end
   endtask

   task automatic test_read_commit();
      exp_b.push_back(2'b00);
      send_both(32'h8, 32'h3, 4'hF);
      wait_b();
      exp_b.push_back(2'b00);
      send_both(32'h8, 32'h5, 4'hF);
      exp_r.push_back({2'b00, 32'h3});
      ar_addr_i = 32'h8; ar_valid_i = 1'b1;
      tick();
      ar_valid_i = 1'b0;
      total++; if ({b_valid_o, r_valid_o} !== 2'b11) begin bad++; $display("FAIL rc_same_edge got=%b exp=11", {b_valid_o, r_valid_o}); end
      wait_r();
      wait_b();
      exp_r.push_back({2'b00, 32'h5});
      send_ar(32'h8);
      wait_r();
   endtask

   task automatic test_reset_mid();
      exp_b.push_back(2'b00);
      send_both(32'h14, 32'h77, 4'hF);
      tick();
      total++; if (b_valid_o !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b exp=1", b_valid_o); end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_b.delete();
      total++; if ({b_valid_o, wr_pulse_o} !== 9'h0) begin bad++; $display("FAIL rm_b got=%h exp=0", {b_valid_o, wr_pulse_o}); end
      total++; if (reg_q_o !== '0) begin bad++; $display("FAIL rm_regs got=%h exp=0", reg_q_o); end
      tick(); tick();
      total++; if (b_valid_o !== 1'b0) begin bad++; $display("FAIL rm_no_b got=%b exp=0", b_valid_o); end
      exp_r.push_back({2'b00, 32'h0});
      send_ar(32'h4);
      wait_r();
   endtask

   initial begin
      rst_i = 1'b1;
      aw_addr_i = '0; aw_valid_i = 1'b0;
      w_data_i = '0; w_strb_i = '0; w_valid_i = 1'b0;
      b_ready_i = 1'b0;
      ar_addr_i = '0; ar_valid_i = 1'b0;
      r_ready_i = 1'b0;
      for (int i = 0; i < NR; i++) ro_d_i[i*DW +: DW] = 32'hBAD00000 | i;
      ro_d_i[0 +: DW] = 32'hCAFE0001;
      test_reset();
      test_basic();
      test_order();
      test_range();
      test_ro();
      test_backpressure();
      test_read_commit();
      test_reset_mid();
      tick(); tick();
      total++; if (exp_b.size() != 0 || exp_r.size() != 0) begin bad++; $display("FAIL sb_leftover got b=%0d r=%0d exp 0", exp_b.size(), exp_r.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite responder (slave) exposing `NUM_REGS` memory-mapped registers of `DATA_WIDTH` bits to an AXI4-Lite initiator. It terminates the five AXI4-Lite channels with flattened ports matching the Slave modport direction and presents register contents and write strobes to the surrounding logic. Typical use is as a control/status register bank behind the crossbar, configured by a host-side AXI-Lite master.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, data width; 32 or 64. `STRB_WIDTH = DATA_WIDTH/8`.
- `NUM_REGS`, 8, register count, ≥2, power of two.
- `RO_MASK`, 0, `NUM_REGS` bits; bit i set makes register i read-only.

Ports:
- `clk_i` in 1: clock, all logic rising-edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `aw_addr_i` in `ADDR_WIDTH`; `aw_valid_i` in 1; `aw_ready_o` out 1.
- `w_data_i` in `DATA_WIDTH`; `w_strb_i` in `STRB_WIDTH`; `w_valid_i` in 1; `w_ready_o` out 1.
- `b_resp_o` out 2; `b_valid_o` out 1; `b_ready_i` in 1.
- `ar_addr_i` in `ADDR_WIDTH`; `ar_valid_i` in 1; `ar_ready_o` out 1.
- `r_data_o` out `DATA_WIDTH`; `r_resp_o` out 2; `r_valid_o` out 1; `r_ready_i` in 1.
- `reg_q_o` out `NUM_REGS*DATA_WIDTH`: register i at slice i; RO slices drive 0.
- `ro_d_i` in `NUM_REGS*DATA_WIDTH`: read value for RO registers; ignored for RW slices.
- `wr_pulse_o` out `NUM_REGS`: one-cycle pulse per committed write to register i.

## Operation
- Decode: `OFS = log2(STRB_WIDTH)`; `idx = addr >> OFS`. `idx < NUM_REGS` → in range; otherwise SLVERR (`2'b10`). Low `OFS` bits ignored (unaligned address maps to containing word). OKAY = `2'b00`.
- Write path, AW and W accepted independently, in either order or same cycle:
  - `aw_ready_o = !aw_held && !b_valid_o`; `w_ready_o = !w_held && !b_valid_o`.
  - On handshake, address / data+strb captured into holding registers, held flag set.
  - Commit: on the first edge where both held flags are set: for in-range RW idx, byte k of register updated iff `w_strb[k]`; `wr_pulse_o[idx]` high for the following cycle; `b_resp_o` = OKAY. Out-of-range or RO idx: no register change, no pulse, `b_resp_o` = SLVERR. Held flags cleared, `b_valid_o` set.
  - All-zero strobe to RW register: no data change, pulse still asserted, OKAY.
  - `b_valid_o` held, `b_resp_o` stable, until `b_ready_i`; clears on handshake edge.
- Read path, one outstanding:
  - `ar_ready_o = !r_valid_o`.
  - On AR handshake: `r_data_o` = register value (RW) or `ro_d_i` slice (RO), sampled at the handshake edge; out of range → `r_data_o = 0`, SLVERR. `r_valid_o` set.
  - `r_valid_o`, `r_data_o`, `r_resp_o` stable until `r_ready_i`.
- Read and write channels fully independent; both may progress in the same cycle.
- Read handshake on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset (`rst_i` high at an edge): all registers 0, held flags cleared; `b_valid_o`, `r_valid_o`, `wr_pulse_o` = 0; `b_resp_o`, `r_resp_o`, `r_data_o` = 0; `aw_ready_o`, `w_ready_o`, `ar_ready_o` = 1 from the cycle after reset. Reset mid-transaction discards it with no B/R response.
- Write latency: last of AW/W handshake at edge E → register updated and `b_valid_o` high after E+1.
- B handshake at edge ≥ E+2; readies reassert the cycle after it. Max write throughput one per 3 cycles.
- Read latency: AR handshake at edge E → `r_valid_o` high after E. With `r_ready_i` held high, one read per 2 cycles.
- No combinational path from any `*_valid_i`/`*_ready_i` to any output.
- Valid never deasserts without handshake.

## Test plan
- Reset then write 0xDEADBEEF, strb 0xF, to 0x4 (AW and W same cycle) → `b_valid_o` one cycle after, OKAY, `wr_pulse_o[1]` one cycle, `reg_q_o` slice 1 = 0xDEADBEEF; read 0x4 returns it, OKAY.
- W three cycles before AW, then AW before W, strb 0x5 over 0xDEADBEEF with 0x11223344 → reg = 0xDE22BE44; `w_ready_o` low while W held.
- Write 0x40 and read 0x40 (NUM_REGS=8, 32-bit) → SLVERR on both, `r_data_o`=0, no pulse, no register change.
- RO_MASK=0x1, `ro_d_i` slice 0 = 0xCAFE0001: write reg 0 → SLVERR, no pulse; read 0x0 → 0xCAFE0001 OKAY.
- `b_ready_i`/`r_ready_i` low 5 cycles → `b_valid_o`/`r_valid_o` and resp/data stable, `aw_ready_o`/`w_ready_o`/`ar_ready_o` low, new AW/W/AR not accepted.
- Read reg 2 on commit edge of write 0x5 over 0x3 → returns 0x3; next read 0x5. Assert `rst_i` with B pending → `b_valid_o` 0, registers 0.
